// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and constants for the branch target buffer
package bp_pkg;
  // Entry fields are sized for the widest legal geometry; unused upper bits stay zero.
  localparam int TAG_MAX_W = 28;
  localparam int CTR_MAX_W = 4;

  localparam logic [CTR_MAX_W-1:0] STRONG_NT = '0;

  typedef enum logic {CLEAR, RUN} bp_state_e;

  typedef struct packed {
    logic [TAG_MAX_W-1:0] tag;
    logic [CTR_MAX_W-1:0] ctr;
    logic [31:0]          target;
  } bp_entry_t;

  function automatic logic [CTR_MAX_W-1:0] weak_t(input int ctr_w);
    return CTR_MAX_W'(1 << (ctr_w - 1));
  endfunction
endpackage

// File: rtl/bp_sat_ctr.sv
// rtl/bp_sat_ctr.sv - combinational saturating increment/decrement of a direction counter
module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_ctr,
  input  logic             i_inc,
  output logic [CTR_W-1:0] o_ctr
);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;

  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != CTR_MAX) o_ctr = i_ctr + 1'b1;
    end else if (i_ctr != CTR_W'(STRONG_NT)) begin
      o_ctr = i_ctr - 1'b1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - tagged BTB with saturating direction counters and clear sweep
// BP_FWD_EN: same-cycle lookup of the entry being updated returns the post-update entry.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 256,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic        halt,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_valid,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic        busy,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);
  localparam int IDX_W = $clog2(ENTRIES);

  bp_state_e          r_state;
  logic [IDX_W-1:0]   r_idx;
  logic [ENTRIES-1:0] r_valid;
  bp_entry_t          r_mem [ENTRIES];
  bp_entry_t          r_rd_ent;
  logic               r_rd_vld;
  logic [TAG_W-1:0]   r_rd_tag;
  logic               r_pred_valid;

  logic [IDX_W-1:0] w_lk_idx, w_upd_idx;
  logic [TAG_W-1:0] w_lk_tag, w_upd_tag;
  logic             w_busy, w_lk_acc, w_upd_acc, w_upd_hit, w_wr_en;
  bp_entry_t        w_upd_old, w_wr_ent;
  logic [CTR_W-1:0] w_sat_ctr;
  logic             w_unused;

  assign w_lk_idx  = lk_pc[IDX_W+1:2];
  assign w_lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign w_busy    = (r_state == CLEAR);
  assign w_lk_acc  = lk_valid && !w_busy && !halt;
  assign w_upd_acc = upd_valid && !w_busy;

  assign w_upd_old = r_mem[w_upd_idx];
  assign w_upd_hit = r_valid[w_upd_idx] && (w_upd_old.tag[TAG_W-1:0] == w_upd_tag);
  // A not-taken branch that misses is not worth a table slot.
  assign w_wr_en   = w_upd_acc && (w_upd_hit || upd_taken);

  bp_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .i_ctr (w_upd_old.ctr[CTR_W-1:0]),
    .i_inc (upd_taken),
    .o_ctr (w_sat_ctr)
  );

  always_comb begin
    w_wr_ent = w_upd_old;
    if (w_upd_hit) begin
      w_wr_ent.ctr = CTR_MAX_W'(w_sat_ctr);
      if (upd_taken) w_wr_ent.target = upd_target;
    end else begin
      w_wr_ent.tag    = TAG_MAX_W'(w_upd_tag);
      w_wr_ent.ctr    = weak_t(CTR_W);
      w_wr_ent.target = upd_target;
    end
  end

`ifdef BP_FWD_EN
  logic w_fwd;
  assign w_fwd = w_wr_en && (w_upd_idx == w_lk_idx);
`endif

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_upd_idx] <= w_wr_ent;
    if (w_lk_acc) begin
`ifdef BP_FWD_EN
      r_rd_ent <= w_fwd ? w_wr_ent : r_mem[w_lk_idx];
`else
      r_rd_ent <= r_mem[w_lk_idx];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state      <= CLEAR;
      r_idx        <= '0;
      r_pred_valid <= 1'b0;
      r_rd_vld     <= 1'b0;
      r_rd_tag     <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_valid[r_idx] <= 1'b0;
          r_idx          <= r_idx + 1'b1;
          if (r_idx == IDX_W'(ENTRIES - 1)) r_state <= RUN;
        end
        RUN: begin
          if (w_wr_en) r_valid[w_upd_idx] <= 1'b1;
        end
        default: r_state <= CLEAR;
      endcase
      if (!halt) r_pred_valid <= w_lk_acc;
      if (w_lk_acc) begin
`ifdef BP_FWD_EN
        r_rd_vld <= w_fwd ? 1'b1 : r_valid[w_lk_idx];
`else
        r_rd_vld <= r_valid[w_lk_idx];
`endif
        r_rd_tag <= w_lk_tag;
      end
    end
  end

  assign busy        = w_busy;
  assign pred_valid  = r_pred_valid;
  assign pred_hit    = r_rd_vld && (r_rd_ent.tag[TAG_W-1:0] == r_rd_tag);
  assign pred_taken  = pred_hit && r_rd_ent.ctr[CTR_W-1];
  assign pred_target = pred_hit ? r_rd_ent.target : 32'h0;

  assign w_unused = ^{lk_pc, upd_pc, r_rd_ent, w_upd_old};
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor (256 entries, 2-bit counters, 8-bit tags)
module tb_branch_predictor;
`ifdef BP_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        halt = 1'b0;
  logic        lk_valid = 1'b0;
  logic [31:0] lk_pc = '0;
  logic        pred_valid, pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        busy;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;

  int checks = 0;
  int failures = 0;
  int n_pred = 0;
  logic [33:0] exp_q[$];

  branch_predictor #(.ENTRIES(256), .CTR_W(2), .TAG_W(8)) dut (
    .clk         (clk),
    .res         (res),
    .halt        (halt),
    .lk_valid    (lk_valid),
    .lk_pc       (lk_pc),
    .pred_valid  (pred_valid),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .busy        (busy),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target)
  );

  always #5 clk = ~clk;

  // Monitor: every fresh prediction (not a halt-held one) consumes one expected entry.
  initial begin
    logic [33:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (pred_valid === 1'b1 && halt === 1'b0) begin
        checks++;
        n_pred++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pred_unexpected n=%0d got=%h exp=none", n_pred,
                   {pred_hit, pred_taken, pred_target});
        end else begin
          exp_v = exp_q.pop_front();
          if ({pred_hit, pred_taken, pred_target} !== exp_v) begin
            failures++;
            $display("FAIL pred n=%0d got=%h exp=%h", n_pred,
                     {pred_hit, pred_taken, pred_target}, exp_v);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tg);
    lk_valid = 1'b1;
    lk_pc    = pc;
    exp_q.push_back({h, t, tg});
    @(negedge clk);
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = t;
    upd_target = tg;
    @(negedge clk);
    upd_valid = 1'b0;
  endtask

  // Counts edges from the current negedge until busy drops; requests pending
  // from the caller are held for exactly the first edge.
  task automatic count_busy(input string name);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        lk_valid  = 1'b0;
        upd_valid = 1'b0;
      end
    end while (busy === 1'b1 && n < 1000);
    check(name, 64'(n), 64'd256);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_pred", 64'({pred_valid, pred_hit, pred_taken, pred_target}), 64'd0);

    // Requests issued on the first sweep cycle must be dropped.
    res = 1'b0;
    lk_valid = 1'b1; lk_pc = 32'h100;
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h44;
    count_busy("busy_len_initial");

    lookup(32'h100, 1'b0, 1'b0, 32'h0);
    lookup(32'h500, 1'b0, 1'b0, 32'h0);

    // Allocate weakly taken, then walk the counter through both saturation points.
    update(32'h100, 1'b1, 32'h80);  lookup(32'h100, 1'b1, 1'b1, 32'h80);
    update(32'h100, 1'b0, 32'hDEAD0); lookup(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b0, 32'hDEAD0); lookup(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b0, 32'hDEAD0); lookup(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b1, 32'h80);  lookup(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b1, 32'h80);  lookup(32'h100, 1'b1, 1'b1, 32'h80);
    update(32'h100, 1'b1, 32'h80);  lookup(32'h100, 1'b1, 1'b1, 32'h80);
    update(32'h100, 1'b1, 32'h80);  lookup(32'h100, 1'b1, 1'b1, 32'h80);
    update(32'h100, 1'b0, 32'h0);   lookup(32'h100, 1'b1, 1'b1, 32'h80);
    update(32'h100, 1'b0, 32'h0);   lookup(32'h100, 1'b1, 1'b0, 32'h80);
    update(32'h100, 1'b1, 32'h84);  lookup(32'h100, 1'b1, 1'b1, 32'h84);

    // Aliasing: 0x500 shares index 0x40 with 0x100 but has tag 1.
    lookup(32'h500, 1'b0, 1'b0, 32'h0);
    update(32'h500, 1'b1, 32'h40);  lookup(32'h500, 1'b1, 1'b1, 32'h40);
    lookup(32'h100, 1'b0, 1'b0, 32'h0);
    update(32'h100, 1'b0, 32'h77);  lookup(32'h500, 1'b1, 1'b1, 32'h40);
    lookup(32'h100, 1'b0, 1'b0, 32'h0);

    // Same-cycle update and lookup of one index.
    upd_valid = 1'b1; upd_pc = 32'h200; upd_taken = 1'b1; upd_target = 32'h300;
    lookup(32'h200, FWD, FWD, FWD ? 32'h300 : 32'h0);
    upd_valid = 1'b0;
    lookup(32'h200, 1'b1, 1'b1, 32'h300);

    // Halt freezes outputs; the update issued during halt still lands.
    lookup(32'h500, 1'b1, 1'b1, 32'h40);
    halt = 1'b1;
    lk_valid = 1'b1; lk_pc = 32'h200;
    upd_valid = 1'b1; upd_pc = 32'h500; upd_taken = 1'b0; upd_target = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      upd_valid = 1'b0;
      check("halt_hold", 64'({pred_valid, pred_hit, pred_taken, pred_target}),
            64'({1'b1, 1'b1, 1'b1, 32'h40}));
    end
    halt = 1'b0;
    lk_valid = 1'b0;
    @(negedge clk);
    check("idle_hold", 64'({pred_valid, pred_hit, pred_taken, pred_target}),
          64'({1'b0, 1'b1, 1'b1, 32'h40}));
    lookup(32'h500, 1'b1, 1'b0, 32'h40);

    // Reset reasserted with the sweep index at 100 restarts the full sweep.
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    repeat (100) @(negedge clk);
    check("busy_mid_sweep", 64'(busy), 64'd1);
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    count_busy("busy_len_restart");
    lookup(32'h500, 1'b0, 1'b0, 32'h0);
    lookup(32'h200, 1'b0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
